seg_display_scan: RTL



---
 rtl/seg_display_scan.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seg_display_scan.sv
// Multi-digit seven-segment driver: static per-digit segments plus a time-multiplexed scan bus.
// Values are double-buffered and only reach the display at frame boundaries, so a frame never tears.
module seg_display_scan #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [FW-1:0]          frame_cnt;
  logic                   blink_phase;
  logic [4*DIGITS-1:0]    active;
  logic [4*DIGITS-1:0]    pending;
  logic [DIGITS-1:0]      active_dp;
  logic [DIGITS-1:0]      pending_dp;
  logic                   pending_valid;

  logic                   tick_c;
  logic                   wrap_c;
  logic [7*DIGITS-1:0]    dec_c;
  logic [6:0]             scan_seg_c;
  logic                   scan_dp_c;

  assign tick_c = (presc == PW'(SCAN_DIV - 1));
  assign wrap_c = tick_c && (idx == IW'(DIGITS - 1));

  function automatic logic [6:0] decode_digit(input logic [3:0] code, input logic hex);
    logic [6:0] s;
    s = SEG_BLANK;
    case (code)
      4'h0: s = SEG_ZERO;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = hex ? 7'h08 : SEG_DASH;
      4'hB: s = hex ? 7'h03 : SEG_DASH;
      4'hC: s = hex ? 7'h46 : SEG_DASH;
      4'hD: s = hex ? 7'h21 : SEG_DASH;
      4'hE: s = hex ? 7'h06 : SEG_DASH;
      4'hF: s = hex ? 7'h0E : SEG_DASH;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Walk from the most-significant digit down so leading-zero state accumulates.
  always_comb begin
    logic       upper_zero;
    logic [3:0] code;
    logic [6:0] s;
    dec_c      = '1;
    upper_zero = 1'b1;
    code       = '0;
    s          = SEG_BLANK;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      code       = active[4*k +: 4];
      upper_zero = upper_zero && (code == 4'h0);
      s          = decode_digit(code, hex_mode);
      if ((lz_blank && upper_zero && (k != 0)) || (blink_en[k] && blink_phase)) begin
        s = SEG_BLANK;
      end
      dec_c[7*k +: 7] = s;
    end
  end

  // Select the currently scanned digit's segments and decimal point.
  always_comb begin
    scan_seg_c = SEG_BLANK;
    scan_dp_c  = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == IW'(k)) begin
        scan_seg_c = dec_c[7*k +: 7];
        scan_dp_c  = ~active_dp[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc         <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      blink_phase   <= 1'b0;
      active        <= '0;
      pending       <= '0;
      active_dp     <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      seg_all       <= {DIGITS{SEG_ZERO}};
      seg           <= SEG_ZERO;
      dp            <= 1'b1;
      an            <= ~(DIGITS'(1));
      frame_start   <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (tick_c) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      // A load coinciding with the wrap bypasses the pending buffer.
      if (wrap_c) begin
        frame_start   <= 1'b1;
        pending_valid <= 1'b0;
        if (load) begin
          active    <= value_in;
          active_dp <= dp_in;
        end else if (pending_valid) begin
          active    <= pending;
          active_dp <= pending_dp;
        end
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else if (load) begin
        pending       <= value_in;
        pending_dp    <= dp_in;
        pending_valid <= 1'b1;
      end

      seg_all <= dec_c;
      seg     <= scan_seg_c;
      dp      <= scan_dp_c;
      an      <= ~(DIGITS'(1) << idx);
    end
  end

endmodule
